// File: rtl/daq_ring_pkg.sv
// Shared widths, field layouts and helpers for the DAQ ring-buffer producer.
package daq_ring_pkg;

  localparam int L1ACNT_W    = 24;
  localparam int L1AMCNT_W   = 12;
  localparam int RING_DW     = 12;

  localparam int L1A_SMP_W   = 38;
  localparam int L1ACNT_LSB  = 0;
  localparam int L1AMCNT_LSB = 24;
  localparam int MATCH_BIT   = 36;
  localparam int PHASE_BIT   = 37;

  localparam int OVRLP_SMP_W = 6;
  localparam int OVLP_CNT_W  = 4;
  localparam int OVLP_BIT    = 4;
  localparam int MULTI_BIT   = 5;

  // Active-window count width; covers up to 31 trackers.
  localparam int ACT_W       = 5;

  typedef struct packed {
    logic                 phase;
    logic                 match;
    logic [L1AMCNT_W-1:0] l1amcnt;
    logic [L1ACNT_W-1:0]  l1acnt;
  } l1a_tag_t;

  typedef struct packed {
    logic                  multi_ovlp;
    logic                  ovlp;
    logic [OVLP_CNT_W-1:0] ovlp_cnt;
  } ovrlp_t;

  function automatic logic [OVLP_CNT_W-1:0] sat_ovlp_cnt(input logic [ACT_W-1:0] active);
    logic [ACT_W-1:0] others;
    others = (active == 5'd0) ? 5'd0 : (active - 5'd1);
    return (others > 5'd15) ? 4'd15 : others[OVLP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ring_win_tracker.sv
// Readout-window down-counters: free-slot pick, active count and per-sample decrement.
module ring_win_tracker
  import daq_ring_pkg::*;
#(
  parameter int NWIN   = 8,
  parameter int SMAX_W = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_smp_en,
  input  logic                  i_load,
  input  logic [SMAX_W-1:0]     i_samp_max,
  output logic [OVLP_CNT_W-1:0] o_ovlp_cnt,
  output logic                  o_ovlp,
  output logic                  o_multi_ovlp,
  output logic                  o_ovf
);

  localparam int IDX_W = $clog2(NWIN);

  logic [SMAX_W-1:0] r_cnt    [NWIN];
  logic [SMAX_W-1:0] w_loaded [NWIN];
  logic              w_free_vld;
  logic              w_hit;
  logic              w_load_ok;
  logic [IDX_W-1:0]  w_free_idx;
  logic [ACT_W-1:0]  w_active;

  // Lowest free slot, tracker view after the load, and overlap from that view.
  always_comb begin
    w_free_vld = 1'b0;
    w_free_idx = '0;
    w_hit      = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      w_hit      = ~w_free_vld & (r_cnt[i] == '0);
      w_free_idx = w_hit ? IDX_W'(i) : w_free_idx;
      w_free_vld = w_free_vld | w_hit;
    end
    w_load_ok = i_load & w_free_vld;
    o_ovf     = i_load & ~w_free_vld;
    w_active  = '0;
    for (int i = 0; i < NWIN; i++) begin
      w_loaded[i] = (w_load_ok && (w_free_idx == IDX_W'(i))) ? i_samp_max : r_cnt[i];
      w_active    = w_active + ACT_W'(w_loaded[i] != '0);
    end
    o_ovlp_cnt   = sat_ovlp_cnt(w_active);
    o_ovlp       = (w_active >= 5'd2);
    o_multi_ovlp = (w_active >= 5'd3);
  end

  // Each open window consumes one sample per strobe, after any load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NWIN; i++) r_cnt[i] <= '0;
    end else if (i_smp_en) begin
      for (int i = 0; i < NWIN; i++)
        r_cnt[i] <= (w_loaded[i] != '0) ? (w_loaded[i] - SMAX_W'(1)) : '0;
    end
  end

endmodule

// File: rtl/ring_smp_writer.sv
// Producer side of the DAQ ring buffer: sample writes, L1A tagging and window overlap.
module ring_smp_writer
  import daq_ring_pkg::*;
#(
  parameter int NWIN   = 8,
  parameter int SMAX_W = 7
) (
  input  logic                   CLK,
  input  logic                   RST_RESYNC,
  input  logic                   SMP_EN,
  input  logic [RING_DW-1:0]     ADC_DATA,
  input  logic                   L1A,
  input  logic                   L1A_MATCH,
  input  logic                   L1A_PHASE,
  input  logic [SMAX_W-1:0]      SAMP_MAX,
  output logic [RING_DW-1:0]     WDATA,
  output logic                   WREN,
  output logic [L1A_SMP_W-1:0]   L1A_SMP_DATA,
  output logic [OVRLP_SMP_W-1:0] OVRLP_SMP_DATA,
  output logic                   L1A_WRT_EN,
  output logic                   L1A_LOST,
  output logic                   WIN_OVF,
  output logic [L1ACNT_W-1:0]    L1A_CNT
);

  logic [RING_DW-1:0]   r_wdata;
  logic                 r_wren;
  l1a_tag_t             r_l1a_smp_data;
  ovrlp_t               r_ovrlp;
  logic                 r_l1a_wrt_en;
  logic                 r_l1a_lost;
  logic                 r_win_ovf;
  logic [L1ACNT_W-1:0]  r_l1acnt;
  logic [L1AMCNT_W-1:0] r_l1amcnt;
  logic                 r_pend_vld;
  l1a_tag_t             r_pend_tag;

  l1a_tag_t              w_new_tag;
  l1a_tag_t              w_cur_tag;
  logic                  w_attach;
  logic                  w_load_req;
  logic [OVLP_CNT_W-1:0] w_ovlp_cnt;
  logic                  w_ovlp;
  logic                  w_multi_ovlp;
  logic                  w_ovf;

  // A same-cycle L1A supersedes any pending tag and can attach immediately.
  always_comb begin
    w_new_tag  = {L1A_PHASE, L1A_MATCH, r_l1amcnt, r_l1acnt};
    w_cur_tag  = L1A ? w_new_tag : r_pend_tag;
    w_attach   = SMP_EN & (L1A | r_pend_vld);
    w_load_req = w_attach & w_cur_tag.match & (SAMP_MAX != '0);
  end

  ring_win_tracker #(
    .NWIN   (NWIN),
    .SMAX_W (SMAX_W)
  ) u_win (
    .i_clk        (CLK),
    .i_rst        (RST_RESYNC),
    .i_smp_en     (SMP_EN),
    .i_load       (w_load_req),
    .i_samp_max   (SAMP_MAX),
    .o_ovlp_cnt   (w_ovlp_cnt),
    .o_ovlp       (w_ovlp),
    .o_multi_ovlp (w_multi_ovlp),
    .o_ovf        (w_ovf)
  );

  // Ring write word and per-sample tag/overlap outputs.
  always_ff @(posedge CLK) begin
    if (RST_RESYNC) begin
      r_wren         <= 1'b0;
      r_wdata        <= '0;
      r_ovrlp        <= '0;
      r_l1a_wrt_en   <= 1'b0;
      r_l1a_smp_data <= '0;
      r_l1a_lost     <= 1'b0;
      r_win_ovf      <= 1'b0;
    end else begin
      r_wren       <= SMP_EN;
      r_l1a_wrt_en <= w_attach;
      r_l1a_lost   <= L1A & r_pend_vld;
      r_win_ovf    <= w_ovf;
      if (SMP_EN) begin
        r_wdata <= ADC_DATA;
        r_ovrlp <= {w_multi_ovlp, w_ovlp, w_ovlp_cnt};
      end
      if (w_attach) r_l1a_smp_data <= w_cur_tag;
    end
  end

  // L1A counters and the single-entry pending tag.
  always_ff @(posedge CLK) begin
    if (RST_RESYNC) begin
      r_l1acnt   <= '0;
      r_l1amcnt  <= '0;
      r_pend_vld <= 1'b0;
      r_pend_tag <= '0;
    end else begin
      if (L1A) begin
        r_l1acnt  <= r_l1acnt + 24'd1;
        r_l1amcnt <= r_l1amcnt + L1AMCNT_W'(L1A_MATCH);
      end
      if (w_attach) begin
        r_pend_vld <= 1'b0;
      end else if (L1A) begin
        r_pend_vld <= 1'b1;
        r_pend_tag <= w_new_tag;
      end
    end
  end

  assign WDATA          = r_wdata;
  assign WREN           = r_wren;
  assign L1A_SMP_DATA   = r_l1a_smp_data;
  assign OVRLP_SMP_DATA = r_ovrlp;
  assign L1A_WRT_EN     = r_l1a_wrt_en;
  assign L1A_LOST       = r_l1a_lost;
  assign WIN_OVF        = r_win_ovf;
  assign L1A_CNT        = r_l1acnt;

endmodule

// File: tb/tb_ring_smp_writer.sv
// Bench for ring_smp_writer: directed steps plus random traffic against a window-list model.
module tb_ring_smp_writer;

  localparam int NWIN   = 8;
  localparam int SMAX_W = 7;

  logic        CLK = 1'b0;
  logic        RST_RESYNC = 1'b1;
  logic        SMP_EN = 1'b0;
  logic [11:0] ADC_DATA = 12'h000;
  logic        L1A = 1'b0;
  logic        L1A_MATCH = 1'b0;
  logic        L1A_PHASE = 1'b0;
  logic [6:0]  SAMP_MAX = 7'd0;
  logic [11:0] WDATA;
  logic        WREN;
  logic [37:0] L1A_SMP_DATA;
  logic [5:0]  OVRLP_SMP_DATA;
  logic        L1A_WRT_EN;
  logic        L1A_LOST;
  logic        WIN_OVF;
  logic [23:0] L1A_CNT;

  ring_smp_writer #(.NWIN(NWIN), .SMAX_W(SMAX_W)) dut (
    .CLK(CLK), .RST_RESYNC(RST_RESYNC), .SMP_EN(SMP_EN), .ADC_DATA(ADC_DATA),
    .L1A(L1A), .L1A_MATCH(L1A_MATCH), .L1A_PHASE(L1A_PHASE), .SAMP_MAX(SAMP_MAX),
    .WDATA(WDATA), .WREN(WREN), .L1A_SMP_DATA(L1A_SMP_DATA),
    .OVRLP_SMP_DATA(OVRLP_SMP_DATA), .L1A_WRT_EN(L1A_WRT_EN), .L1A_LOST(L1A_LOST),
    .WIN_OVF(WIN_OVF), .L1A_CNT(L1A_CNT)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: counters, one pending tag, and a list of open windows (samples left).
  logic [23:0] m_l1acnt;
  logic [11:0] m_l1amcnt;
  bit          m_pend_vld;
  logic [37:0] m_pend_tag;
  int          m_samp_max;
  int          wins[$];

  logic [11:0] e_wdata;
  logic        e_wren;
  logic [37:0] e_tag;
  logic [5:0]  e_ovrlp;
  logic        e_wrt_en;
  logic        e_lost;
  logic        e_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("WREN",           64'(WREN),           64'(e_wren));
    chk("WDATA",          64'(WDATA),          64'(e_wdata));
    chk("L1A_WRT_EN",     64'(L1A_WRT_EN),     64'(e_wrt_en));
    chk("L1A_SMP_DATA",   64'(L1A_SMP_DATA),   64'(e_tag));
    chk("OVRLP_SMP_DATA", 64'(OVRLP_SMP_DATA), 64'(e_ovrlp));
    chk("L1A_LOST",       64'(L1A_LOST),       64'(e_lost));
    chk("WIN_OVF",        64'(WIN_OVF),        64'(e_ovf));
    chk("L1A_CNT",        64'(L1A_CNT),        64'(m_l1acnt));
  endtask

  task automatic do_reset();
    SMP_EN = 1'b0; L1A = 1'b0; RST_RESYNC = 1'b1;
    @(posedge CLK); #1;
    RST_RESYNC = 1'b0;
    m_l1acnt = '0; m_l1amcnt = '0; m_pend_vld = 0; m_pend_tag = '0;
    wins.delete();
    e_wdata = '0; e_wren = 0; e_tag = '0; e_ovrlp = '0; e_wrt_en = 0; e_lost = 0; e_ovf = 0;
    chk_all();
  endtask

  // One clock: drive inputs, advance the model by the spec rules, then check outputs.
  task automatic step(input bit smp, input bit l1a, input bit match, input bit phase,
                      input logic [11:0] adc);
    int a;
    int nq[$];
    SMP_EN = smp; ADC_DATA = adc; L1A = l1a; L1A_MATCH = match; L1A_PHASE = phase;
    e_lost   = l1a && m_pend_vld;
    e_ovf    = 0;
    e_wrt_en = 0;
    e_wren   = smp;
    if (l1a) begin
      m_pend_tag = {phase, match, m_l1amcnt, m_l1acnt};
      m_pend_vld = 1;
      m_l1acnt   = m_l1acnt + 24'd1;
      if (match) m_l1amcnt = m_l1amcnt + 12'd1;
    end
    if (smp && m_pend_vld) begin
      e_wrt_en   = 1;
      e_tag      = m_pend_tag;
      m_pend_vld = 0;
      if (m_pend_tag[36] && m_samp_max != 0) begin
        if (wins.size() < NWIN) wins.push_back(m_samp_max);
        else e_ovf = 1;
      end
    end
    if (smp) begin
      e_wdata = adc;
      a = wins.size();
      e_ovrlp = {a >= 3, a >= 2, 4'((a == 0) ? 0 : ((a - 1 > 15) ? 15 : a - 1))};
      foreach (wins[i]) if (wins[i] > 1) nq.push_back(wins[i] - 1);
      wins = nq;
    end
    @(posedge CLK); #1;
    SMP_EN = 1'b0; L1A = 1'b0; L1A_MATCH = 1'b0; L1A_PHASE = 1'b0;
    chk_all();
  endtask

  initial begin
    m_samp_max = 7; SAMP_MAX = 7'd7;
    do_reset();

    // Idle strobes every 8 cycles, fixed data, no tags or windows.
    repeat (4) begin
      step(1, 0, 0, 0, 12'h0A5);
      chk("plain_wdata", 64'(WDATA), 64'h0A5);
      repeat (7) step(0, 0, 0, 0, 12'h000);
    end

    // First matched L1A three cycles ahead of a strobe; window spans 7 samples.
    step(0, 1, 1, 0, 12'h000);
    step(0, 0, 0, 0, 12'h000);
    step(0, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 12'($urandom));
    chk("first_tag", 64'(L1A_SMP_DATA), 64'h10_0000_0000);
    chk("first_cnt", 64'(L1A_CNT), 64'd1);
    repeat (9) begin
      step(1, 0, 0, 0, 12'($urandom));
      step(0, 0, 0, 0, 12'h000);
    end

    // Overlapping windows opened at samples 0, 3 and 5.
    do_reset();
    for (int s = 0; s < 12; s++) begin
      step(1, (s == 0) || (s == 3) || (s == 5), 1, s[0], 12'($urandom));
      if (s == 5) chk("triple_ovlp", 64'(OVRLP_SMP_DATA), 64'h32);
    end

    // Unmatched L1A: tag pushed, no window.
    step(1, 1, 0, 1, 12'($urandom));
    repeat (3) step(1, 0, 0, 0, 12'($urandom));

    // Two L1As between strobes collide.
    do_reset();
    step(0, 1, 1, 0, 12'h000);
    step(0, 1, 0, 1, 12'h000);
    step(0, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 12'($urandom));
    chk("collide_l1acnt", 64'(L1A_SMP_DATA[23:0]), 64'd1);
    chk("collide_cnt", 64'(L1A_CNT), 64'd2);

    // Tracker exhaustion with long windows, then resync mid-window with a tag pending.
    m_samp_max = 127; SAMP_MAX = 7'd127;
    do_reset();
    for (int s = 0; s < 9; s++) step(1, 1, 1, 0, 12'($urandom));
    chk("ovf_flag", 64'(WIN_OVF), 64'd1);
    chk("ovf_cnt", 64'(OVRLP_SMP_DATA[3:0]), 64'd7);
    repeat (3) step(1, 0, 0, 0, 12'($urandom));
    step(0, 1, 1, 1, 12'h000);
    do_reset();
    repeat (3) step(1, 0, 0, 0, 12'($urandom));
    step(1, 1, 1, 0, 12'($urandom));

    // Random traffic over several window lengths, including zero.
    for (int r = 0; r < 4; r++) begin
      m_samp_max = (r == 0) ? 0 : int'($urandom_range(1, 12));
      SAMP_MAX = 7'(m_samp_max);
      do_reset();
      repeat (150) step(($urandom % 3) == 0, ($urandom % 6) == 0, $urandom % 2 == 1,
                        $urandom % 2 == 1, 12'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_smp_writer.md
Name: ring_smp_writer

Overview:
Producer side of the DAQ ring-buffer interface. It registers ADC samples into ring write words (WDATA/WREN) and tags L1As. It also tracks open readout windows so that every sample carries overlap information. It generates L1A_SMP_DATA / OVRLP_SMP_DATA / L1A_WRT_EN exactly as the ring-buffer reader consumes them, and sits between the ADC deserializer and the ring buffer.

Parameters:
NWIN, 8, number of concurrent readout-window trackers (2..15)
SMAX_W, 7, width of SAMP_MAX

Ports:
CLK  in  1  system clock
RST_RESYNC  in  1  synchronous active-high reset
SMP_EN  in  1  one-cycle strobe: ADC_DATA valid, one sample
ADC_DATA  in  12  ADC sample
L1A  in  1  level-1 accept pulse
L1A_MATCH  in  1  qualifies L1A for readout
L1A_PHASE  in  1  L1A phase bit, sampled with L1A
SAMP_MAX  in  7  readout window length in samples (static between resyncs)
WDATA  out  12  ring write data
WREN  out  1  ring write enable
L1A_SMP_DATA  out  38  {phase, match, l1amcnt[11:0], l1acnt[23:0]}
OVRLP_SMP_DATA  out  6  {multi_ovlp, ovlp, ovlp_cnt[3:0]}
L1A_WRT_EN  out  1  L1A tag valid on this write
L1A_LOST  out  1  pulse: pending L1A overwritten
WIN_OVF  out  1  pulse: matched L1A found no free tracker
L1A_CNT  out  24  current L1A counter (status)

Behaviour:
- Reset: all outputs 0; l1acnt=0, l1amcnt=0; pending cleared; all trackers 0.
- Every output is registered. Latency from the SMP_EN cycle to the WREN cycle is 1.
  - WREN = registered SMP_EN.
  - WDATA = ADC_DATA captured in the SMP_EN cycle.
- L1A counters:
  - On L1A, the pending tag loads {L1A_PHASE, L1A_MATCH, l1amcnt, l1acnt}, using the pre-increment values.
  - In the same cycle, l1acnt increments; l1amcnt increments only if L1A_MATCH.
  - Both counters wrap modulo 2^24 and 2^12.
  - L1A_CNT = l1acnt.
- Tag attach:
  - The pending tag attaches to the first SMP_EN at or after the L1A; an L1A in the same cycle as SMP_EN attaches to that sample.
  - That sample's write has L1A_WRT_EN=1 and L1A_SMP_DATA = tag; pending then clears.
  - When L1A_WRT_EN=0, L1A_SMP_DATA holds its last value.
- Collision: an L1A while a tag is still pending overwrites the pending tag and pulses L1A_LOST in the next cycle. Counters still increment for both L1As.
- Window trackers (NWIN down-counters, SMAX_W bits):
  - A matched L1A's tag attach loads the lowest-index zero tracker with SAMP_MAX.
  - If SAMP_MAX==0, no tracker is loaded.
  - If no tracker is free, none is loaded and WIN_OVF pulses; the tag push still occurs.
- Overlap per sample, evaluated in the SMP_EN cycle after the load:
  - A = count of nonzero trackers.
  - ovlp_cnt = A-1 saturated at 15 (0 if A==0).
  - ovlp = (A>=2); multi_ovlp = (A>=3).
  - These are registered with WDATA.
- After evaluation, each nonzero tracker decrements by 1. A window therefore covers exactly SAMP_MAX samples, starting at the tagged sample.
- Simultaneous load and decrement of the same tracker: load first, then decrement, so the tracker holds SAMP_MAX-1 after that sample.
- RST_RESYNC mid-window: everything clears next cycle. Any pending tag is dropped with no L1A_LOST.

Decomposition:
- Shared package daq_ring_pkg holds:
  - the field widths and bit positions of L1A_SMP_DATA (38) and OVRLP_SMP_DATA (6);
  - L1ACNT_W=24, L1AMCNT_W=12, RING_DW=12.
- One sub-module, ring_win_tracker:
  - contents: NWIN counters, free-slot priority encoder, active popcount;
  - outputs: ovlp_cnt/ovlp/multi_ovlp and overflow.

Test Plan:
- Reset, then SMP_EN every 8 cycles with ADC_DATA=0x0A5 -> WREN one cycle after each strobe, WDATA=0x0A5, L1A_WRT_EN=0, OVRLP_SMP_DATA=0.
- SAMP_MAX=7; matched L1A 3 cycles before a strobe (first L1A after reset):
  - the next write has L1A_WRT_EN=1 and L1A_SMP_DATA={0,1,0x000,0x000000};
  - 7 writes carry A=1 (ovlp=0, ovlp_cnt=0), then A=0;
  - L1A_CNT=1.
- SAMP_MAX=7; matched L1As on samples 0 and 3 -> samples 3..6 carry ovlp=1, ovlp_cnt=1; the second tag has l1amcnt=1, l1acnt=1. A third matched L1A at sample 5 makes samples 5..6 multi_ovlp=1, ovlp_cnt=2.
- Unmatched L1A -> push with match=0, l1amcnt unchanged, no tracker loaded, overlap 0.
- Two L1As between strobes -> L1A_LOST pulses once; the attached tag has l1acnt=1 and L1A_CNT=2.
- NWIN=8, SAMP_MAX=127; 9 matched L1As on consecutive samples -> the 9th gives WIN_OVF=1 and a push with ovlp_cnt=7. Then assert RST_RESYNC mid-window -> all outputs and counters return to 0.
